// File: rtl/data_memory.sv
// data_memory: fixed-latency data RAM with sized loads/stores, sign/zero extension and alignment checking.
// Define DMEM_POSTED_STORE_EN to write legal stores immediately without stalling the pipeline.
module data_memory #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        load,
    input  logic        store,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic        stall,
    output logic [31:0] mem_dout,
    output logic        misalign
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t                state;
    logic [3:0]            cnt, cnt_next;
    logic [31:0]           ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           rdata, ext, wide;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic [3:0]            be;
    logic                  legal, acc, fire, we, unused_addr;

    assign idx         = addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^addr[31:ADDR_WIDTH+2];
    assign misalign    = (load | store) & ((load & store) | (size == 2'b11) |
                         ((size == 2'b01) & addr[0]) | ((size == 2'b10) & (addr[1:0] != 2'b00)));
    assign legal       = (load ^ store) & ~misalign;
`ifdef DMEM_POSTED_STORE_EN
    assign acc = legal & load;
    assign we  = rst_n & legal & store & (state != BUSY);
`else
    assign acc = legal;
    assign we  = rst_n & fire & store;
`endif
    assign stall    = acc & (state != DONE);
    // Counting starts at 1 in the request cycle itself, so stall lasts exactly LATENCY cycles
    assign cnt_next = (state == IDLE) ? 4'd1 : cnt + 4'd1;
    assign fire     = (((state == IDLE) & acc) | (state == BUSY)) & (cnt_next == 4'(LATENCY));

    assign rdata = ram[idx];
    assign rbyte = rdata[{addr[1:0], 3'b000} +: 8];
    assign rhalf = addr[1] ? rdata[31:16] : rdata[15:0];
    assign ext   = (size == 2'b00) ? {{24{rbyte[7] & ~ld_unsigned}}, rbyte} :
                   (size == 2'b01) ? {{16{rhalf[15] & ~ld_unsigned}}, rhalf} : rdata;
    assign be    = (size == 2'b00) ? 4'b0001 << addr[1:0] :
                   (size == 2'b01) ? {addr[1], addr[1], ~addr[1], ~addr[1]} : 4'b1111;
    assign wide  = (size == 2'b00) ? {4{wdata[7:0]}} :
                   (size == 2'b01) ? {2{wdata[15:0]}} : wdata;

    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (we & be[i]) ram[idx][8*i +: 8] <= wide[8*i +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            mem_dout <= 32'd0;
        end else begin
            unique case (state)
                IDLE: if (acc) begin
                    cnt   <= cnt_next;
                    state <= fire ? DONE : BUSY;
                end
                BUSY: begin
                    cnt   <= cnt_next;
                    state <= fire ? DONE : BUSY;
                end
                default: begin
                    cnt   <= 4'd0;
                    state <= IDLE;
                end
            endcase
            if (fire & load) mem_dout <= ext;
        end
    end
endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Data-side memory responder for the 5-stage pipeline. It serves the load/store requests issued in the MEM stage and returns mem_dout to the MEM/WB register.
- Fixed-latency synchronous RAM with byte/halfword/word access, sign/zero extension on loads, alignment checking, and a combinational stall back to the pipeline while an access is in flight.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth is 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, stall cycles per access; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- addr  input  32  byte address of the access. Only bits [ADDR_WIDTH+1:0] are used; upper bits are ignored, so addresses wrap modulo the RAM size.
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- load  input  1  load request.
- store  input  1  store request.
- size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- ld_unsigned  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- stall  output  1  combinational; 1 = pipeline must hold all request inputs stable.
- mem_dout  output  32  registered, extended load result.
- misalign  output  1  combinational; illegal or misaligned request, no access performed.

Behaviour:
- Byte order is little-endian: addr[1:0]=0 selects bits [7:0]. Halfword at addr[1]=1 occupies [31:16].
- States are IDLE, BUSY and DONE. A 4-bit counter cnt runs in BUSY.
- A request is valid when load^store is 1.
- misalign = (load|store) & (load&store | size==11 | size==01&addr[0] | size==10&addr[1:0]!=0).
  - A misaligned or illegal request performs no RAM access and leaves the state unchanged.
  - stall stays 0 for such a request; the pipeline handles the exception.
- stall = valid & ~misalign & (state != DONE).
- IDLE: on a legal valid request, go to BUSY with cnt=1.
- BUSY: cnt increments each cycle. When cnt==LATENCY, go to DONE.
  - On that same edge, a store writes its byte lanes and a load registers the extended result into mem_dout.
- DONE: stall=0 for exactly one cycle, so the pipeline advances. Next state is IDLE unconditionally.
- Stall length: exactly LATENCY cycles per legal access (with LATENCY=2: stall high for 2 cycles, low in the 3rd).
- A new request in the cycle after DONE starts a fresh access; there is no pipelining between accesses.
- Store byte enables: byte lane addr[1:0]; half lanes {addr[1],0}+1..0; word all four lanes. Unselected bytes are unchanged.
- mem_dout holds its value until the next load completes. Stores and misaligned requests do not change it.
- Reset values: state IDLE, cnt 0, mem_dout 0. stall and misalign then follow their equations.
- RAM contents are not cleared by reset.
- Reset asserted mid-access aborts the access with no write and no mem_dout update. After release, a still-present request restarts from cnt=1.
- Request inputs changing while stall=1 is a protocol violation; behaviour is undefined.

Optional Feature:
- Macro DMEM_POSTED_STORE_EN.
- Defined: a legal store is written on the rising edge of its first request cycle, with stall=0 throughout and the state held in IDLE. A load in the following cycle to the same address returns the new data. Loads are unchanged.
- Undefined: stores take LATENCY stall cycles exactly like loads.

Test Plan:
- Word store addr=0x10, wdata=0xDEADBEEF, then word load addr=0x10 (LATENCY=2) -> each access stalls exactly 2 cycles; mem_dout=0xDEADBEEF in the load's DONE cycle.
- Byte store 0x80 to addr=0x13, then lb and lbu at 0x13 -> mem_dout=0xFFFFFF80 then 0x00000080; word load at 0x10 returns 0x80ADBEEF.
- Halfword load addr=0x11 -> misalign=1, stall=0, mem_dout unchanged; same with size=11, and with load=store=1.
- Word load addr=0x10 with rst_n pulsed low during cycle 1 of BUSY -> mem_dout=0; after release, a 2-cycle stall, then 0x80ADBEEF.
- addr=0x00001010 with ADDR_WIDTH=10 -> aliases addr 0x10; store then load returns the written value.
- With DMEM_POSTED_STORE_EN defined: sw 0x12345678 to 0x20 with no stall, then an immediate lw 0x20 -> 2-cycle stall, returns 0x12345678.
